// File: rtl/imul_dot_acc.sv
// rtl/imul_dot_acc.sv - dot-product accumulator over N_TERMS unsigned 8-bit products
// Optional saturation on overflow: define IMUL_DOT_ACC_SAT_EN.
module imul_dot_acc #(
    parameter int ACC_SIZE = 16,
    parameter int N_TERMS  = 4,
    parameter int CNT_SIZE = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iStart,
    input  logic                iValid,
    input  logic [7:0]          iProduct,
    output logic                oReady,
    output logic                oValid,
    input  logic                iAck,
    output logic [ACC_SIZE-1:0] oResult,
    output logic                oOverflow,
    output logic                oBusy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_SIZE-1:0] LAST_CNT = CNT_SIZE'(N_TERMS - 1);

    logic [1:0]          r_state;
    logic [ACC_SIZE-1:0] r_acc;
    logic [CNT_SIZE-1:0] r_cnt;
    logic                r_ovf;

    logic                w_accept;
    logic                w_restart;
    logic [ACC_SIZE:0]   w_sum;
    logic                w_carry;
    logic [ACC_SIZE-1:0] w_acc_next;

    assign w_accept  = (r_state == S_ACC) && iValid;
    assign w_restart = ((r_state == S_IDLE) && iStart) ||
                       ((r_state == S_DONE) && iAck && iStart);

    assign w_sum   = {1'b0, r_acc} + {{(ACC_SIZE - 7){1'b0}}, iProduct};
    assign w_carry = w_sum[ACC_SIZE];

`ifdef IMUL_DOT_ACC_SAT_EN
    // Once saturated, any later add either carries again or adds zero, so all ones sticks.
    assign w_acc_next = w_carry ? {ACC_SIZE{1'b1}} : w_sum[ACC_SIZE-1:0];
`else
    assign w_acc_next = w_sum[ACC_SIZE-1:0];
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_restart) begin
            r_state <= S_ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            r_ovf <= r_ovf | w_carry;
            if (r_cnt == LAST_CNT) begin
                r_state <= S_DONE;
            end
        end else if ((r_state == S_DONE) && iAck) begin
            r_state <= S_IDLE;
        end
    end

    assign oReady    = (r_state == S_ACC);
    assign oValid    = (r_state == S_DONE);
    assign oBusy     = (r_state != S_IDLE);
    assign oResult   = r_acc;
    assign oOverflow = r_ovf;

endmodule

// File: tb/tb_imul_dot_acc.sv
// tb/tb_imul_dot_acc.sv - directed self-checking bench for imul_dot_acc (16-bit and 9-bit instances)
module tb_imul_dot_acc;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iStart = 1'b0;
    logic        iValid = 1'b0;
    logic [7:0]  iProduct = 8'd0;
    logic        iAck = 1'b0;

    logic        a_ready, a_valid, a_ovf, a_busy;
    logic [15:0] a_result;
    logic        b_ready, b_valid, b_ovf, b_busy;
    logic [8:0]  b_result;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 Clock = ~Clock;

    imul_dot_acc #(.ACC_SIZE(16), .N_TERMS(4), .CNT_SIZE(8)) u_dut16 (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iValid(iValid),
        .iProduct(iProduct), .oReady(a_ready), .oValid(a_valid), .iAck(iAck),
        .oResult(a_result), .oOverflow(a_ovf), .oBusy(a_busy)
    );

    imul_dot_acc #(.ACC_SIZE(9), .N_TERMS(4), .CNT_SIZE(8)) u_dut9 (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iValid(iValid),
        .iProduct(iProduct), .oReady(b_ready), .oValid(b_valid), .iAck(iAck),
        .oResult(b_result), .oOverflow(b_ovf), .oBusy(b_busy)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic send(input logic [7:0] p);
        iValid = 1'b1; iProduct = p; tick();
        iValid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iStart = 1'($urandom); iValid = 1'($urandom);
            iProduct = 8'($urandom); iAck = 1'($urandom);
            tick();
            tests_run++;
            if ({a_ready, a_valid, a_ovf, a_busy, a_result} !== 20'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs16 cyc %0d: got %h expected 0", i, {a_ready, a_valid, a_ovf, a_busy, a_result});
            end
            tests_run++;
            if ({b_ready, b_valid, b_ovf, b_busy, b_result} !== 13'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs9 cyc %0d: got %h expected 0", i, {b_ready, b_valid, b_ovf, b_busy, b_result});
            end
        end
        iStart = 1'b0; iValid = 1'b0; iAck = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        iValid = 1'b1; iProduct = 8'd77;
        tick(); tick();
        iValid = 1'b0;
        tests_run++;
        if ({a_ready, a_busy, a_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_flags: got %b expected 000", {a_ready, a_busy, a_valid});
        end
        tests_run++;
        if (a_result !== 16'd0) begin
            tests_failed++;
            $display("FAIL idle_acc_unchanged: got %0d expected 0", a_result);
        end
    endtask

    task automatic test_basic_sum();
        logic [7:0] prods [4] = '{8'd225, 8'd15, 8'd0, 8'd100};
        iStart = 1'b1; tick(); iStart = 1'b0;
        tests_run++;
        if ({a_ready, a_busy, a_valid} !== 3'b110) begin
            tests_failed++;
            $display("FAIL start_to_acc: got %b expected 110", {a_ready, a_busy, a_valid});
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (a_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL early_valid before accept %0d: got %b expected 0", i, a_valid);
            end
            send(prods[i]);
        end
        tests_run++;
        if ({a_valid, a_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL basic_done_flags: got %b expected 10", {a_valid, a_ready});
        end
        tests_run++;
        if (a_result !== 16'd340 || a_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_sum: got %0d ovf %b expected 340 ovf 0", a_result, a_ovf);
        end
        iAck = 1'b1; tick(); iAck = 1'b0;
        tests_run++;
        if ({a_valid, a_busy, a_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL ack_to_idle: got %b expected 000", {a_valid, a_busy, a_ready});
        end
    endtask

    task automatic test_stalls();
        logic [7:0] prods [4] = '{8'd225, 8'd15, 8'd0, 8'd100};
        iStart = 1'b1; tick(); iStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iProduct = 8'd255;
            for (int g = 0; g <= (i % 3); g++) tick();
            tests_run++;
            if ({a_ready, a_valid} !== 2'b10) begin
                tests_failed++;
                $display("FAIL stall_flags gap %0d: got %b expected 10", i, {a_ready, a_valid});
            end
            send(prods[i]);
        end
        iValid = 1'b1; iProduct = 8'd200;
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (a_valid !== 1'b1 || a_ready !== 1'b0 || a_result !== 16'd340) begin
                tests_failed++;
                $display("FAIL hold_done cyc %0d: got v%b r%b %0d expected v1 r0 340", c, a_valid, a_ready, a_result);
            end
            tick();
        end
        iValid = 1'b0;
        iAck = 1'b1; tick(); iAck = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] prods [4] = '{8'd225, 8'd225, 8'd100, 8'd0};
        logic [8:0] exp9;
`ifdef IMUL_DOT_ACC_SAT_EN
        exp9 = 9'd511;
`else
        exp9 = 9'd38;
`endif
        iStart = 1'b1; tick(); iStart = 1'b0;
        for (int i = 0; i < 4; i++) send(prods[i]);
        tests_run++;
        if (b_valid !== 1'b1 || b_result !== exp9 || b_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow9: got v%b %0d ovf %b expected v1 %0d ovf 1", b_valid, b_result, b_ovf, exp9);
        end
        tests_run++;
        if (a_result !== 16'd550 || a_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_overflow16: got %0d ovf %b expected 550 ovf 0", a_result, a_ovf);
        end
    endtask

    task automatic test_ack_start();
        iAck = 1'b1; iStart = 1'b1; tick(); iAck = 1'b0; iStart = 1'b0;
        tests_run++;
        if ({a_valid, a_ready, a_busy} !== 3'b011) begin
            tests_failed++;
            $display("FAIL collision_flags: got %b expected 011", {a_valid, a_ready, a_busy});
        end
        tests_run++;
        if (b_result !== 9'd0 || b_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision_clear: got %0d ovf %b expected 0 ovf 0", b_result, b_ovf);
        end
        for (int i = 1; i <= 4; i++) send(8'(i));
        tests_run++;
        if (a_valid !== 1'b1 || a_result !== 16'd10 || b_result !== 9'd10) begin
            tests_failed++;
            $display("FAIL collision_sum: got v%b %0d/%0d expected v1 10/10", a_valid, a_result, b_result);
        end
        iAck = 1'b1; tick(); iAck = 1'b0;
    endtask

    task automatic test_reset_mid();
        iStart = 1'b1; tick(); iStart = 1'b0;
        send(8'd7); send(8'd9);
        #2 Reset = 1'b0;
        #1;
        tests_run++;
        if ({a_busy, a_ready, a_ovf} !== 3'b000 || a_result !== 16'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %b %0d expected 000 0", {a_busy, a_ready, a_ovf}, a_result);
        end
        tick();
        Reset = 1'b1;
        tick();
        iStart = 1'b1; tick(); iStart = 1'b0;
        for (int i = 0; i < 4; i++) send(8'd5);
        tests_run++;
        if (a_valid !== 1'b1 || a_result !== 16'd20 || a_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_sum: got v%b %0d ovf %b expected v1 20 ovf 0", a_valid, a_result, a_ovf);
        end
        iAck = 1'b1; tick(); iAck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_stalls();
        test_overflow();
        test_ack_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imul_dot_acc.md
# imul_dot_acc

Sequential dot-product accumulator that sits directly downstream of the combinational 4x4 unsigned multiplier stage. It consumes a stream of 8-bit products over a valid/ready handshake and sums exactly N_TERMS of them into an ACC_SIZE-bit accumulator. It then presents the sum on a held valid/ack output. Overflow is flagged; saturation is optional.

## Interface
- ACC_SIZE, 16: accumulator/result width; legal range 8..32.
- N_TERMS, 4: products summed per operation; legal range 1..255.
- CNT_SIZE, 8: term counter width; must satisfy 2^CNT_SIZE > N_TERMS.

- Clock  input  1  single system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- iStart  input  1  single-cycle request to begin a new dot product.
- iValid  input  1  iProduct carries a valid product this cycle.
- iProduct  input  8  unsigned product from the multiplier stage.
- oReady  output  1  block accepts a product this cycle.
- oValid  output  1  oResult holds a completed sum.
- iAck  input  1  downstream consumes oResult.
- oResult  output  ACC_SIZE  accumulated sum.
- oOverflow  output  1  sticky; the sum exceeded 2^ACC_SIZE-1 during this operation.
- oBusy  output  1  state is not IDLE.

## Operation
- FSM states: IDLE, ACC, DONE; all outputs are registered except oReady/oValid/oBusy, which are decoded from state.
- Accept: a product is accepted on a rising edge where iValid=1 and oReady=1.
- IDLE:
  - oReady=0, oValid=0.
  - iStart=1 -> ACC; acc<=0, cnt<=0, overflow<=0.
- ACC:
  - oReady=1.
  - On each accept: {carry,sum} = acc + {0,iProduct} at ACC_SIZE+1 bits.
  - Then acc<=sum, cnt<=cnt+1, overflow<=overflow|carry.
  - When the accept hits cnt==N_TERMS-1 -> DONE.
  - iStart is ignored; iValid=0 cycles stall with no change.
- DONE:
  - oValid=1; oResult and oOverflow are held stable; oReady=0.
  - iAck=1 -> IDLE.
  - iAck=1 with iStart=1 in the same cycle -> ACC directly, with acc, cnt and overflow cleared.
- oResult always mirrors acc; it is meaningful only while oValid=1.
- Products arriving while oReady=0 are not consumed. The upstream stage holds them.

## Timing
- Reset asserted, asynchronously:
  - State=IDLE; acc, cnt, oResult, oOverflow = 0.
  - oValid, oReady, oBusy = 0.
- Reset mid-operation aborts; the partial sum is discarded.
- Deassertion is sampled on the next rising edge.
- iStart at edge t:
  - oReady=1 and oBusy=1 from cycle t+1.
- Throughput: one product per cycle.
- Latency: oValid=1 in the cycle after the N_TERMS-th accept, so N_TERMS+1 cycles minimum from iStart to oValid.
- oValid stays high for as many cycles as iAck stays low. There is no timeout.
- Ack turnaround: iAck at edge t makes oValid=0 at t+1. With iStart also at t, oReady=1 at t+1.
- N_TERMS=1: a single accept moves ACC -> DONE.
- Overflow detection is per add. Once set, oOverflow remains 1 until the next start or reset.

## Configuration
- IMUL_DOT_ACC_SAT_EN defined:
  - An add with carry=1 loads acc with all ones.
  - All further adds in this operation keep all ones.
  - oOverflow is still set.
- Undefined: the sum wraps modulo 2^ACC_SIZE; oOverflow is still set.

## Test plan
- Reset/idle: hold Reset=0 with random inputs -> all outputs 0; iValid=1 in IDLE -> oReady=0 and acc unchanged.
- Basic sum (ACC_SIZE=16, N_TERMS=4):
  - Stimulus: iStart, then products 225,15,0,100 back to back.
  - Required: oValid=1 one cycle after the 4th accept, oResult=340, oOverflow=0.
- Stalls and back-pressure:
  - Stimulus: same products with iValid gaps of 1-3 cycles; iAck held low for 5 cycles.
  - Required: oResult=340 held stable for 5 cycles; iValid ignored in DONE.
- Overflow (ACC_SIZE=9, N_TERMS=4): products 225,225,100,0 -> without macro oResult=38, oOverflow=1; with IMUL_DOT_ACC_SAT_EN oResult=511, oOverflow=1.
- Ack+start collision:
  - Stimulus: in DONE, iAck=1 and iStart=1 in the same cycle, then products 1,2,3,4.
  - Required: next oResult=10, with no IDLE cycle between operations.
- Reset mid-operation:
  - Stimulus: assert Reset after 2 of 4 accepts; restart and send 4 products of 5.
  - Required: oResult=20 (the partial sum from before reset is discarded), oOverflow=0.
